// File: rtl/cla_pkg.sv
// Shared constants for the carry-lookahead adder family.
// Group width and the group-count helper live here so every user agrees on them.
package cla_pkg;

  localparam int CLA_GROUP_W = 4;

  function automatic int ngroups(input int n);
    return (n + CLA_GROUP_W - 1) / CLA_GROUP_W;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit lookahead group: local sum bits plus group propagate/generate.
// Internal carries are flat sums of products, so there is no ripple path inside the group.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       p_grp,
  output logic       g_grp
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

  assign p_grp = &p;
  assign g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_parameterized.sv
// n-bit two-level carry-lookahead adder with a registered {cout, sum} result.
// Operands are zero-padded up to a whole number of 4-bit groups.
module cla_parameterized
  import cla_pkg::*;
#(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout,
  output logic [n:0]   final_sum
);

  localparam int NG = ngroups(n);
  localparam int W  = NG * CLA_GROUP_W;

  logic [W-1:0]  a_pad;
  logic [W-1:0]  b_pad;
  logic [W-1:0]  s_pad;
  logic [NG-1:0] grp_p;
  logic [NG-1:0] grp_g;
  logic [NG:0]   grp_c;
  logic          cout_d;
  logic          unused_bits;

  assign a_pad    = W'(a);
  assign b_pad    = W'(b);
  assign grp_c[0] = cin;

  for (genvar j = 0; j < NG; j++) begin : g_group
    cla_group4 u_group (
      .a     (a_pad[CLA_GROUP_W*j +: CLA_GROUP_W]),
      .b     (b_pad[CLA_GROUP_W*j +: CLA_GROUP_W]),
      .ci    (grp_c[j]),
      .s     (s_pad[CLA_GROUP_W*j +: CLA_GROUP_W]),
      .p_grp (grp_p[j]),
      .g_grp (grp_g[j])
    );
  end

  // Each group carry is a flat OR of products: cin or some G*[k], qualified by every P* above it.
  for (genvar j = 0; j < NG; j++) begin : g_carry
    logic [j+1:0] terms;
    always_comb begin
      terms    = '0;
      terms[0] = cin;
      for (int m = 0; m <= j; m++) terms[0] = terms[0] & grp_p[m];
      for (int k = 0; k <= j; k++) begin
        terms[k+1] = grp_g[k];
        for (int m = k + 1; m <= j; m++) terms[k+1] = terms[k+1] & grp_p[m];
      end
    end
    assign grp_c[j+1] = |terms;
  end

  // With a partial last group the first pad bit has p=0, so its sum bit is exactly the carry out of bit n-1.
  if (n % CLA_GROUP_W == 0) begin : g_cout_full
    assign cout_d = grp_c[NG];
  end else begin : g_cout_part
    assign cout_d = s_pad[n];
  end

  assign unused_bits = ^{grp_c[NG], s_pad};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= s_pad[n-1:0];
      cout <= cout_d;
    end
  end

  assign final_sum = {cout, sum};

endmodule

// File: tb/tb_cla_parameterized.sv
// Self-checking bench for cla_parameterized at n=16, n=5 and n=1.
// An arithmetic reference model is compared every cycle, plus hand-computed literals.
module tb_cla_parameterized;

  logic        clk;
  logic        rst;
  logic [15:0] a16, b16;
  logic        cin16;
  logic [4:0]  a5, b5;
  logic        cin5;
  logic [0:0]  a1, b1;
  logic        cin1;

  logic [15:0] sum16;
  logic        cout16;
  logic [16:0] final16;
  logic [4:0]  sum5;
  logic        cout5;
  logic [5:0]  final5;
  logic [0:0]  sum1;
  logic        cout1;
  logic [1:0]  final1;

  logic [16:0] m16;
  logic [5:0]  m5;
  logic [1:0]  m1;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  cla_parameterized #(.n(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16),
    .sum(sum16), .cout(cout16), .final_sum(final16)
  );

  cla_parameterized #(.n(5)) dut5 (
    .clk(clk), .rst(rst), .a(a5), .b(b5), .cin(cin5),
    .sum(sum5), .cout(cout5), .final_sum(final5)
  );

  cla_parameterized #(.n(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .final_sum(final1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width sum of the operands seen at each edge, cleared asynchronously by reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m16 <= '0;
      m5  <= '0;
      m1  <= '0;
    end else begin
      m16 <= 17'(a16) + 17'(b16) + 17'(cin16);
      m5  <= 6'(a5) + 6'(b5) + 6'(cin5);
      m1  <= 2'(a1) + 2'(b1) + 2'(cin1);
    end
  end

  task automatic checkOutput(input string name, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Drive the same vector to every width (truncated), just after a falling edge.
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    @(negedge clk);
    a16 = va;      b16 = vb;      cin16 = vc;
    a5  = va[4:0]; b5  = vb[4:0]; cin5  = vc;
    a1  = va[0];   b1  = vb[0];   cin1  = vc;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model n16 final_sum", final16, m16);
      checkOutput("model n16 {cout,sum}", {cout16, sum16}, m16);
      checkOutput("model n5 final_sum", 17'(final5), 17'(m5));
      checkOutput("model n1 final_sum", 17'(final1), 17'(m1));
    end
  end

  initial begin
    logic [31:0] ra, rb, rc;
    rst = 1'b1;
    applyStimulus(16'hFFFF, 16'h0001, 1'b1);
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset sum", 17'(sum16), 17'h0);
    checkOutput("reset cout", 17'(cout16), 17'h0);
    checkOutput("reset final_sum", final16, 17'h0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("first after release", final16, 17'h10001);

    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    @(posedge clk); #1;
    checkOutput("propagate chain", final16, 17'h10000);

    applyStimulus(16'h8000, 16'h8000, 1'b0);
    @(posedge clk); #1;
    checkOutput("generate msb", final16, 17'h10000);

    applyStimulus(16'h1234, 16'h4321, 1'b0);
    @(posedge clk); #1;
    checkOutput("1234+4321", final16, 17'h05555);

    #2 rst = 1'b1;
    #1;
    checkOutput("async reset clears", final16, 17'h0);

    @(negedge clk);
    rst = 1'b0;
    a16 = 16'h000F; b16 = 16'h0001; cin16 = 1'b0;
    a5  = 5'h0F;    b5  = 5'h01;    cin5  = 1'b0;
    a1  = 1'b1;     b1  = 1'b1;     cin1  = 1'b0;
    @(posedge clk); #1;
    checkOutput("group boundary 000F+1", final16, 17'h00010);

    applyStimulus(16'h0FFF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    checkOutput("group boundary 0FFF+1", final16, 17'h01000);

    applyStimulus(16'h001F, 16'h0001, 1'b1);
    @(posedge clk); #1;
    checkOutput("n5 sum", 17'(sum5), 17'h01);
    checkOutput("n5 cout", 17'(cout5), 17'h1);
    checkOutput("n5 final_sum", 17'(final5), 17'h21);
    checkOutput("n1 1+1+1", 17'(final1), 17'h3);

    for (int i = 0; i < 8; i++) begin
      applyStimulus({15'b0, i[2]}, {15'b0, i[1]}, i[0]);
      @(posedge clk); #1;
      checkOutput("n1 exhaustive", 17'(final1), 17'(i[2] + i[1] + i[0]));
    end

    repeat (200) begin
      ra = $random; rb = $random; rc = $random;
      applyStimulus(ra[15:0], rb[15:0], rc[0]);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
